// File: rtl/loa_stream_accumulator.sv
`default_nettype none
// ============================================================================
// loa_stream_accumulator : sums LEN signed terms with lower-part-OR addition
// Revision : 1.0
// ============================================================================
module loa_stream_accumulator #(
  parameter int IGNORE_BIT = 0,
  parameter int WIDTH_IN   = 16,
  parameter int WIDTH_ACC  = 32,
  parameter int LEN_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [LEN_W-1:0]     len,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH_IN-1:0]  in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH_ACC-1:0] out_data,
  output logic                 busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH_ACC-1:0] acc_q, acc_d;
  logic [LEN_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH_ACC-1:0] term_ext;
  logic [WIDTH_ACC-1:0] loa_sum;

  assign term_ext = WIDTH_ACC'($signed(in_data));

  generate
    if (IGNORE_BIT == 0) begin : g_exact
      assign loa_sum = acc_q + term_ext;
    end else begin : g_loa
      logic [IGNORE_BIT-1:0]           low;
      logic                            carry;
      logic [WIDTH_ACC-IGNORE_BIT-1:0] high;
      // Low bits are OR-ed; their top bit pair still feeds a carry upward.
      assign low   = acc_q[IGNORE_BIT-1:0] | term_ext[IGNORE_BIT-1:0];
      assign carry = acc_q[IGNORE_BIT-1] & term_ext[IGNORE_BIT-1];
      assign high  = acc_q[WIDTH_ACC-1:IGNORE_BIT] + term_ext[WIDTH_ACC-1:IGNORE_BIT]
                   + (WIDTH_ACC-IGNORE_BIT)'(carry);
      assign loa_sum = {high, low};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = '0;
          cnt_d   = len;
          state_d = (len == '0) ? S_HOLD : S_ACC;
        end
      end
      S_ACC: begin
        if (in_valid) begin
          acc_d = loa_sum;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == LEN_W'(1)) begin
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == S_ACC);
  assign out_valid = (state_q == S_HOLD);
  assign busy      = (state_q != S_IDLE);
  assign out_data  = acc_q;

endmodule
`default_nettype wire

// File: tb/tb_loa_stream_accumulator.sv
`default_nettype none
// ============================================================================
// tb_loa_stream_accumulator : three parameterisations driven by one stream
// Revision : 1.0
// ============================================================================
module tb_loa_stream_accumulator;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_ready;

  logic [2:0]  in_ready_v, out_valid_v, busy_v;
  logic [31:0] out_data_a, out_data_b;
  logic [15:0] out_data_c;
  logic [31:0] od [3];

  int n_checks = 0;
  int n_fail   = 0;

  // Instance parameters: a = exact/32, b = LOA k=4/32, c = exact/16.
  int K [3] = '{0, 4, 0};
  int W [3] = '{32, 32, 16};

  loa_stream_accumulator #(.IGNORE_BIT(0), .WIDTH_IN(16), .WIDTH_ACC(32), .LEN_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .in_valid(in_valid),
    .in_ready(in_ready_v[0]), .in_data(in_data), .out_valid(out_valid_v[0]),
    .out_ready(out_ready), .out_data(out_data_a), .busy(busy_v[0]));

  loa_stream_accumulator #(.IGNORE_BIT(4), .WIDTH_IN(16), .WIDTH_ACC(32), .LEN_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .in_valid(in_valid),
    .in_ready(in_ready_v[1]), .in_data(in_data), .out_valid(out_valid_v[1]),
    .out_ready(out_ready), .out_data(out_data_b), .busy(busy_v[1]));

  loa_stream_accumulator #(.IGNORE_BIT(0), .WIDTH_IN(16), .WIDTH_ACC(16), .LEN_W(8)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .in_valid(in_valid),
    .in_ready(in_ready_v[2]), .in_data(in_data), .out_valid(out_valid_v[2]),
    .out_ready(out_ready), .out_data(out_data_c), .busy(busy_v[2]));

  assign od[0] = out_data_a;
  assign od[1] = out_data_b;
  assign od[2] = {16'h0000, out_data_c};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // LOA addition computed arithmetically on plain integers.
  function automatic longint loa_m(input longint x, input longint y, input int k, input int w);
    longint mask_w, mask_k, low, c, high;
    mask_w = (longint'(1) << w) - 1;
    mask_k = (longint'(1) << k) - 1;
    low    = (x | y) & mask_k;
    c      = (k > 0) ? (((x >> (k - 1)) & (y >> (k - 1))) & 1) : 0;
    high   = ((x & mask_w) >> k) + ((y & mask_w) >> k) + c;
    return ((high << k) | low) & mask_w;
  endfunction

  // Model: 0 = waiting for a job, 1 = collecting terms, 2 = offering result.
  int     phase;
  int     remaining;
  longint exp_acc [3];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase = 0;
      remaining = 0;
      for (int i = 0; i < 3; i++) exp_acc[i] = 0;
    end else begin
      case (phase)
        0: if (start) begin
          for (int i = 0; i < 3; i++) exp_acc[i] = 0;
          remaining = int'(len);
          phase = (len == 8'd0) ? 2 : 1;
        end
        1: if (in_valid) begin
          for (int i = 0; i < 3; i++)
            exp_acc[i] = loa_m(exp_acc[i],
                               longint'($signed(in_data)) & ((longint'(1) << W[i]) - 1),
                               K[i], W[i]);
          remaining--;
          if (remaining == 0) phase = 2;
        end
        default: if (out_ready) phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("in_ready[%0d]", i), {31'd0, in_ready_v[i]}, {31'd0, phase == 1});
        check($sformatf("out_valid[%0d]", i), {31'd0, out_valid_v[i]}, {31'd0, phase == 2});
        check($sformatf("busy[%0d]", i), {31'd0, busy_v[i]}, {31'd0, phase != 0});
        if (phase != 1)
          check($sformatf("out_data[%0d]", i), od[i], exp_acc[i][31:0]);
      end
    end
  end

  task automatic start_job(input logic [7:0] l);
    start = 1'b1;
    len   = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [15:0] t);
    logic hs;
    bit   done;
    done     = 0;
    in_valid = 1'b1;
    in_data  = t;
    for (int i = 0; i < 20 && !done; i++) begin
      hs = in_ready_v[0];
      @(posedge clk); #1;
      if (hs) done = 1;
    end
    in_valid = 1'b0;
    if (!done) check("send_timeout", 32'd1, 32'd0);
  endtask

  task automatic drain(input int stall);
    logic hs;
    bit   done;
    done      = 0;
    out_ready = 1'b0;
    repeat (stall) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      hs = out_valid_v[0];
      @(posedge clk); #1;
      if (hs) done = 1;
    end
    out_ready = 1'b0;
    if (!done) check("drain_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; len = 8'd0;
    in_valid = 1'b0; in_data = 16'h0; out_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_out_valid", {29'd0, out_valid_v}, 32'd0);
    check("rst_in_ready", {29'd0, in_ready_v}, 32'd0);
    check("rst_busy", {29'd0, busy_v}, 32'd0);
    check("rst_out_data", out_data_a, 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Exact sum 1+2+3-10.
    start_job(8'd4);
    send(16'd1); send(16'd2); send(16'd3);
    check("t1_no_early_valid", {31'd0, out_valid_v[0]}, 32'd0);
    send(16'hFFF6);
    check("t1_valid_after_last", {31'd0, out_valid_v[0]}, 32'd1);
    check("t1_sum", out_data_a, 32'hFFFFFFFC);
    drain(0);
    @(posedge clk); #1;

    // LOA error on instance b.
    start_job(8'd2);
    send(16'h0008); send(16'h0008);
    check("t2_loa", out_data_b, 32'h00000018);
    check("t2_exact", out_data_a, 32'h00000010);
    drain(0);

    // Backpressure: gaps between terms, stalled output, START/IN_VALID ignored in HOLD.
    start_job(8'd3);
    send(16'd5);
    @(posedge clk); #1;
    send(16'hFFFF);
    @(posedge clk); #1;
    send(16'd100);
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'd9;
    drain(5);
    start    = 1'b0;
    in_valid = 1'b0;
    check("t3_sum", out_data_a, 32'h00000068);
    check("t3_idle", {31'd0, busy_v[0]}, 32'd0);
    @(posedge clk); #1;
    check("t3_stays_idle", {31'd0, busy_v[0]}, 32'd0);

    // Zero length.
    start_job(8'd0);
    check("t4_valid", {31'd0, out_valid_v[0]}, 32'd1);
    check("t4_data", out_data_a, 32'd0);
    check("t4_in_ready", {31'd0, in_ready_v[0]}, 32'd0);
    drain(1);

    // Reset mid-job.
    start_job(8'd4);
    send(16'd11); send(16'd22);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_busy", {29'd0, busy_v}, 32'd0);
    check("t5_rst_in_ready", {29'd0, in_ready_v}, 32'd0);
    check("t5_rst_valid", {29'd0, out_valid_v}, 32'd0);
    check("t5_rst_data", out_data_a, 32'd0);
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    start_job(8'd1);
    send(16'd7);
    check("t5_data", out_data_a, 32'd7);
    check("t5_data_loa", out_data_b, 32'd7);
    drain(0);

    // Wrap-around on the 16-bit instance.
    start_job(8'd2);
    send(16'h7FFF); send(16'h0001);
    check("t6_wrap", {16'h0000, out_data_c}, 32'h00008000);
    drain(2);
    repeat (3) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
